// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin scheduler sharing one registered 4-bit ALU between two requesters,
// with per-requester carry flags and error responses for illegal opcodes and ALU timeouts.
module alu_arbiter #(
  parameter int TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [7:0] req_ctl,
  output logic [1:0] rsp_valid,
  input  logic [1:0] rsp_ready,
  output logic [3:0] rsp_alu,
  output logic       rsp_carry,
  output logic       rsp_zero,
  output logic       rsp_err,
  output logic       alu_valid_in,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_cin,
  output logic [3:0] alu_ctl,
  input  logic       alu_valid_out,
  input  logic [3:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_zero
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic rr_ptr, owner, win, any_req, legal, timed_out;
  logic [1:0] cflag;
  logic [7:0] cnt;
  logic [3:0] sel_a, sel_b, sel_ctl;
  always_comb begin
    any_req = |req_valid;
    win = &req_valid ? rr_ptr : req_valid[1];
    sel_a = win ? req_a[7:4] : req_a[3:0];
    sel_b = win ? req_b[7:4] : req_b[3:0];
    sel_ctl = win ? req_ctl[7:4] : req_ctl[3:0];
    legal = sel_ctl <= 4'hD;
    timed_out = cnt == 8'(TIMEOUT - 1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = any_req ? (legal ? ISSUE : RESP) : IDLE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = (alu_valid_out || timed_out) ? RESP : WAIT;
      default: state_nx = rsp_ready[owner] ? IDLE : RESP;
    endcase
  end
  // req_ready is gated by reset so every output reads zero while reset is held
  always_comb begin
    req_ready = (state == IDLE && any_req && !reset) ? (win ? 2'b10 : 2'b01) : 2'b00;
    rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    alu_valid_in = state == ISSUE;
  end
  // ALU operand registers load only for legal accepts, so they hold until the next issue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= 1'b0;
      owner <= 1'b0;
      cflag <= '0;
      cnt <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_ctl <= '0;
      alu_cin <= 1'b0;
      rsp_alu <= '0;
      rsp_carry <= 1'b0;
      rsp_zero <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      if (state == IDLE && any_req) begin
        owner <= win;
        rr_ptr <= ~win;
        if (legal) begin
          alu_a <= sel_a;
          alu_b <= sel_b;
          alu_ctl <= sel_ctl;
          alu_cin <= cflag[win];
        end else begin
          rsp_alu <= '0;
          rsp_carry <= 1'b0;
          rsp_zero <= 1'b0;
          rsp_err <= 1'b1;
        end
      end
      if (state == ISSUE) cnt <= '0;
      if (state == WAIT) begin
        if (alu_valid_out) begin
          rsp_alu <= alu_result;
          rsp_carry <= alu_carry;
          rsp_zero <= alu_zero;
          rsp_err <= 1'b0;
          cflag[owner] <= alu_carry;
        end else if (timed_out) begin
          rsp_alu <= '0;
          rsp_carry <= 1'b0;
          rsp_zero <= 1'b0;
          rsp_err <= 1'b1;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a registered ALU model (ctl 4 adds carry-in).
module tb_alu_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = 2'b11;
  logic [7:0] req_a = '0, req_b = '0, req_ctl = '0;
  logic [3:0] rsp_alu, alu_a, alu_b, alu_ctl, alu_result;
  logic rsp_carry, rsp_zero, rsp_err, alu_valid_in, alu_cin;
  logic alu_valid_out = 1'b0, alu_carry = 1'b0, alu_zero = 1'b0;
  logic alu_en = 1'b1;
  logic [4:0] sum;
  int total = 0, bad = 0, vin_cnt = 0, v = 0, n = 0;

  alu_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctl(req_ctl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_alu(rsp_alu), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_valid_in(alu_valid_in), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_ctl(alu_ctl),
    .alu_valid_out(alu_valid_out), .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  assign sum = {1'b0, alu_a} + {1'b0, alu_b} + ((alu_ctl == 4'd4) ? {4'b0, alu_cin} : 5'd0);
  always @(posedge clk) begin
    alu_valid_out <= alu_valid_in & alu_en;
    {alu_carry, alu_result} <= sum;
    alu_zero <= sum[3:0] == 4'd0;
    if (alu_valid_in === 1'b1) vin_cnt <= vin_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] vld, input logic [3:0] a, input logic [3:0] b, input logic [3:0] ctl);
    req_valid = vld;
    req_a = {a, a};
    req_b = {b, b};
    req_ctl = {ctl, ctl};
  endtask

  task automatic op(input logic id, input logic [3:0] a, input logic [3:0] b, input logic [3:0] ctl,
                    input logic cin, input logic [3:0] r, input logic c, input logic z);
    set_req(id ? 2'b10 : 2'b01, a, b, ctl);
    #1 chk("grant", req_ready, id ? 2'b10 : 2'b01);
    step();
    req_valid = 2'b00;
    chk("issue", {alu_valid_in, alu_a, alu_b, alu_ctl, alu_cin}, {1'b1, a, b, ctl, cin});
    step();
    chk("wait_vin", alu_valid_in, 1'b0);
    step();
    chk("rsp", {rsp_valid, rsp_alu, rsp_carry, rsp_zero, rsp_err}, {id ? 2'b10 : 2'b01, r, c, z, 1'b0});
    step();
    chk("rsp_done", rsp_valid, 2'b00);
  endtask

  initial begin
    repeat (2) step();
    chk("reset_out", {req_ready, rsp_valid, alu_valid_in, alu_a, alu_b, alu_cin, alu_ctl,
                      rsp_alu, rsp_carry, rsp_zero, rsp_err}, 32'd0);
    reset = 1'b0;
    step();
    chk("idle_out", {req_ready, rsp_valid, alu_valid_in}, 32'd0);
    // basic add, carry chain, zero result
    op(1'b0, 4'd3, 4'd4, 4'd3, 1'b0, 4'd7, 1'b0, 1'b0);
    op(1'b0, 4'd9, 4'd9, 4'd3, 1'b0, 4'd2, 1'b1, 1'b0);
    op(1'b0, 4'd1, 4'd1, 4'd4, 1'b1, 4'd3, 1'b0, 1'b0);
    op(1'b1, 4'd1, 4'd1, 4'd4, 1'b0, 4'd2, 1'b0, 1'b0);
    op(1'b1, 4'd8, 4'd8, 4'd3, 1'b0, 4'd0, 1'b1, 1'b1);
    // illegal opcode from r1 goes straight to an error response
    v = vin_cnt;
    set_req(2'b10, 4'd5, 4'd6, 4'hE);
    #1 chk("ill_grant", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    chk("ill_rsp", {rsp_valid, rsp_alu, rsp_carry, rsp_zero, rsp_err, alu_valid_in}, {2'b10, 4'h0, 4'b0010});
    step();
    chk("ill_done", rsp_valid, 2'b00);
    chk("ill_nopulse", vin_cnt, v);
    op(1'b1, 4'd0, 4'd0, 4'd4, 1'b1, 4'd1, 1'b0, 1'b0);
    // ALU never answers: timeout error, then normal service resumes
    alu_en = 1'b0;
    set_req(2'b01, 4'd2, 4'd3, 4'd3);
    #1 step();
    req_valid = 2'b00;
    chk("to_issue", alu_valid_in, 1'b1);
    n = 0;
    while (rsp_valid == 2'b00 && n < 30) begin
      step();
      n++;
    end
    chk("to_rsp", {rsp_valid, rsp_alu, rsp_carry, rsp_zero, rsp_err}, {2'b01, 4'h0, 3'b001});
    step();
    alu_en = 1'b1;
    chk("to_done", rsp_valid, 2'b00);
    op(1'b0, 4'd2, 4'd3, 4'd3, 1'b0, 4'd5, 1'b0, 1'b0);
    // reset while waiting on the ALU
    op(1'b0, 4'd9, 4'd9, 4'd3, 1'b0, 4'd2, 1'b1, 1'b0);
    set_req(2'b01, 4'd1, 4'd1, 4'd4);
    #1 step();
    req_valid = 2'b00;
    chk("rw_cin", {alu_valid_in, alu_cin}, 2'b11);
    step();
    reset = 1'b1;
    req_valid = 2'b11;
    req_a = 8'h51;
    req_b = 8'h62;
    req_ctl = 8'h44;
    #1 chk("rw_out", {req_ready, rsp_valid, alu_valid_in, alu_a, alu_b, alu_cin, alu_ctl,
                      rsp_alu, rsp_carry, rsp_zero, rsp_err}, 32'd0);
    step();
    reset = 1'b0;
    #1 chk("rw_norsp", rsp_valid, 2'b00);
    // contention: grants alternate starting at r0, cflags cleared by reset
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (req_ready == 2'b00 && n < 10) begin
        step();
        n++;
      end
      chk("rr_grant", req_ready, k[0] ? 2'b10 : 2'b01);
      step();
      chk("rr_cin", alu_cin, 1'b0);
      n = 0;
      while (rsp_valid == 2'b00 && n < 10) begin
        step();
        n++;
      end
      chk("rr_rsp", {rsp_valid, rsp_alu}, k[0] ? {2'b10, 4'd11} : {2'b01, 4'd3});
      step();
    end
    n = 0;
    while (req_ready == 2'b00 && n < 10) begin
      step();
      n++;
    end
    chk("hold_grant", req_ready, 2'b01);
    rsp_ready = 2'b10;
    step();
    n = 0;
    while (rsp_valid == 2'b00 && n < 10) begin
      step();
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      chk("hold_rsp", {req_ready, rsp_valid, rsp_alu, rsp_carry, rsp_zero, rsp_err}, {2'b00, 2'b01, 4'd3, 3'b000});
      step();
    end
    rsp_ready = 2'b11;
    step();
    chk("hold_release", {rsp_valid, req_ready}, {2'b00, 2'b10});
    req_valid = 2'b00;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
